rob_mw: RTL and testbench

Parametrised multi-way reorder buffer for the out-of-order core. Dispatch allocates up to PUSH_WIDTH entries per cycle and receives a slot tag for each. Execution units mark entries complete by tag, in any order, on up to CMPLT_PORTS ports. Commit retires up to RETIRE_WIDTH consecutive completed entries per cycle, in program order. A single-cycle flush empties the buffer.

---
 rtl/rob_mw_if.sv | 34 +++
 rtl/rob_mw.sv | 113 +++++++++++
 tb/tb_rob_mw.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_mw_if.sv
// Dispatch / completion / commit bus of the multi-way reorder buffer.
// Lane 0 of every multi-lane field sits in the LSBs and is the oldest lane.
interface rob_mw_if #(
  parameter int DATA_WIDTH   = 11,
  parameter int PUSH_WIDTH   = 3,
  parameter int RETIRE_WIDTH = 3,
  parameter int CMPLT_PORTS  = 3,
  parameter int DEPTH        = 16
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(PUSH_WIDTH) + 1;
  localparam int RW = $clog2(RETIRE_WIDTH) + 1;

  logic                                    flush;
  logic [PUSH_WIDTH-1:0][DATA_WIDTH-1:0]   din;
  logic [PW-1:0]                           din_valid_ct;
  logic [PW-1:0]                           din_ready_ct;
  logic [PUSH_WIDTH-1:0][AW-1:0]           din_tags;
  logic [CMPLT_PORTS-1:0][AW-1:0]          cmplt_tags;
  logic [CMPLT_PORTS-1:0]                  cmplt_valid;
  logic [RETIRE_WIDTH-1:0][DATA_WIDTH-1:0] dout;
  logic [RW-1:0]                           dout_valid_ct;
  logic [RW-1:0]                           dout_ready_ct;
  logic [AW:0]                             count;

  modport master (
    output flush, din, din_valid_ct, cmplt_tags, cmplt_valid, dout_ready_ct,
    input  din_ready_ct, din_tags, dout, dout_valid_ct, count
  );
  modport slave (
    input  flush, din, din_valid_ct, cmplt_tags, cmplt_valid, dout_ready_ct,
    output din_ready_ct, din_tags, dout, dout_valid_ct, count
  );
endinterface

// File: rtl/rob_mw.sv
// Multi-way reorder buffer: N-wide allocate, tag-addressed out-of-order completion,
// in-order N-wide retire of consecutive completed entries, single-cycle flush.
module rob_mw #(
  parameter int DATA_WIDTH   = 11,
  parameter int PUSH_WIDTH   = 3,
  parameter int RETIRE_WIDTH = 3,
  parameter int CMPLT_PORTS  = 3,
  parameter int DEPTH        = 16
) (
  input  logic      clk,
  input  logic      rst,
  rob_mw_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(PUSH_WIDTH) + 1;
  localparam int RW = $clog2(RETIRE_WIDTH) + 1;

  logic [AW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [AW:0]           count_q, count_d;
  logic [DEPTH-1:0]      valid_q, valid_d, done_q, done_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] ready_ct, npush;
  logic [RW-1:0] vld_ct, nret;

  // Ready depends only on registered count; same-cycle retires free nothing.
  always_comb begin
    logic [AW:0]   free;
    logic [PW-1:0] req;
    free     = (AW+1)'(DEPTH) - count_q;
    ready_ct = (free >= (AW+1)'(PUSH_WIDTH)) ? PW'(PUSH_WIDTH) : PW'(free);
    req      = (bus.din_valid_ct > PW'(PUSH_WIDTH)) ? PW'(PUSH_WIDTH) : bus.din_valid_ct;
    npush    = (req < ready_ct) ? req : ready_ct;
  end

  always_comb begin
    logic          run;
    logic [AW-1:0] slot;
    logic [RW-1:0] rreq;
    run    = 1'b1;
    slot   = '0;
    vld_ct = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      slot = head_q + AW'(i);
      if (run && valid_q[slot] && done_q[slot]) vld_ct = vld_ct + RW'(1);
      else                                      run    = 1'b0;
    end
    rreq = (bus.dout_ready_ct > RW'(RETIRE_WIDTH)) ? RW'(RETIRE_WIDTH) : bus.dout_ready_ct;
    nret = (rreq < vld_ct) ? rreq : vld_ct;
  end

  // Completions test registered valid, so a slot pushed this cycle ignores them.
  // Push slots are always empty and retire slots always occupied, so they never overlap.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    for (int p = 0; p < CMPLT_PORTS; p++)
      if (bus.cmplt_valid[p] && valid_q[bus.cmplt_tags[p]]) done_d[bus.cmplt_tags[p]] = 1'b1;
    for (int i = 0; i < RETIRE_WIDTH; i++)
      if (RW'(i) < nret) begin
        valid_d[head_q + AW'(i)] = 1'b0;
        done_d[head_q + AW'(i)]  = 1'b0;
      end
    for (int i = 0; i < PUSH_WIDTH; i++)
      if (PW'(i) < npush) begin
        valid_d[tail_q + AW'(i)] = 1'b1;
        done_d[tail_q + AW'(i)]  = 1'b0;
      end
    head_d  = head_q + AW'(nret);
    tail_d  = tail_q + AW'(npush);
    count_d = count_q + (AW+1)'(npush) - (AW+1)'(nret);
    if (bus.flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Payload is unreset; stray writes under flush/reset land in slots marked invalid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PUSH_WIDTH; i++)
      if (PW'(i) < npush) mem_q[tail_q + AW'(i)] <= bus.din[i];
  end

  assign bus.din_ready_ct  = ready_ct;
  assign bus.dout_valid_ct = vld_ct;
  assign bus.count         = count_q;

  for (genvar i = 0; i < PUSH_WIDTH; i++) begin : g_tag
    assign bus.din_tags[i] = tail_q + AW'(i);
  end
  for (genvar i = 0; i < RETIRE_WIDTH; i++) begin : g_dout
    assign bus.dout[i] = mem_q[head_q + AW'(i)];
  end
endmodule

// File: tb/tb_rob_mw.sv
// Directed bench for rob_mw: occupancy-list model checked every cycle, plus literal pins.
module tb_rob_mw;
  localparam int DW = 11, PWD = 3, RWD = 3, CP = 3, DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rob_mw_if #(.DATA_WIDTH(DW), .PUSH_WIDTH(PWD), .RETIRE_WIDTH(RWD),
              .CMPLT_PORTS(CP), .DEPTH(DEPTH)) bus ();

  rob_mw #(.DATA_WIDTH(DW), .PUSH_WIDTH(PWD), .RETIRE_WIDTH(RWD),
           .CMPLT_PORTS(CP), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int pay_seq = 100;

  // Model: program-order window starting at mhead holding mcount entries.
  bit          mv [DEPTH];
  bit          md [DEPTH];
  logic [DW-1:0] mp [DEPTH];
  int          mhead  = 0;
  int          mcount = 0;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int m_ready();
    return imin(PWD, DEPTH - mcount);
  endfunction

  function automatic int m_vct();
    int n;
    n = 0;
    while (n < RWD && n < mcount && mv[(mhead + n) % DEPTH] && md[(mhead + n) % DEPTH]) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int vct, np, nr, tl, tg;
    if (rst || bus.flush) begin
      for (int s = 0; s < DEPTH; s++) begin mv[s] = 0; md[s] = 0; end
      mhead = 0;
      mcount = 0;
    end else begin
      vct = m_vct();
      np  = imin(imin(int'(bus.din_valid_ct), PWD), m_ready());
      nr  = imin(vct, imin(int'(bus.dout_ready_ct), RWD));
      for (int p = 0; p < CP; p++) begin
        tg = int'(bus.cmplt_tags[p]);
        if (bus.cmplt_valid[p] && mv[tg]) md[tg] = 1;
      end
      for (int i = 0; i < nr; i++) begin
        mv[(mhead + i) % DEPTH] = 0;
        md[(mhead + i) % DEPTH] = 0;
      end
      tl = (mhead + mcount) % DEPTH;
      for (int i = 0; i < np; i++) begin
        mv[(tl + i) % DEPTH] = 1;
        md[(tl + i) % DEPTH] = 0;
        mp[(tl + i) % DEPTH] = bus.din[i];
      end
      mhead  = (mhead + nr) % DEPTH;
      mcount = mcount + np - nr;
    end
  end

  always @(negedge clk) begin : compare
    int vct;
    if (chk_en) begin
      vct = m_vct();
      chk("count", 32'(bus.count), 32'(mcount));
      chk("din_ready_ct", 32'(bus.din_ready_ct), 32'(m_ready()));
      chk("dout_valid_ct", 32'(bus.dout_valid_ct), 32'(vct));
      for (int i = 0; i < PWD; i++)
        chk("din_tags", 32'(bus.din_tags[i]), 32'((mhead + mcount + i) % DEPTH));
      for (int i = 0; i < vct; i++)
        chk("dout", 32'(bus.dout[i]), 32'(mp[(mhead + i) % DEPTH]));
    end
  end

  task automatic idle();
    bus.flush         = 1'b0;
    bus.din           = '0;
    bus.din_valid_ct  = '0;
    bus.cmplt_tags    = '0;
    bus.cmplt_valid   = '0;
    bus.dout_ready_ct = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic push(input int n);
    bus.din_valid_ct = 3'(n);
    for (int i = 0; i < PWD; i++) bus.din[i] = DW'(pay_seq + i);
    pay_seq += PWD;
  endtask

  task automatic cmp(input int p, input int tag);
    bus.cmplt_valid[p] = 1'b1;
    bus.cmplt_tags[p]  = 4'(tag);
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
  endtask

  task automatic round(input int n, input int t0);
    push(n); tick();
    for (int i = 0; i < n; i++) cmp(i, t0 + i);
    tick();
    bus.dout_ready_ct = 3'(RWD); tick();
  endtask

  initial begin : stim
    int base;
    idle();
    @(posedge clk); @(negedge clk);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_ready", 32'(bus.din_ready_ct), 3);
    chk("rst_vct", 32'(bus.dout_valid_ct), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // fill with no completions
    for (int k = 0; k < 5; k++) begin
      chk("fill_tag0", 32'(bus.din_tags[0]), 32'(3 * k));
      push(3); tick();
    end
    chk("fill15_count", 32'(bus.count), 15);
    chk("fill15_ready", 32'(bus.din_ready_ct), 1);
    push(3); tick();
    chk("full_count", 32'(bus.count), 16);
    chk("full_ready", 32'(bus.din_ready_ct), 0);
    push(3); tick();
    chk("full_hold", 32'(bus.count), 16);
    do_flush();
    chk("flush_count", 32'(bus.count), 0);

    // out-of-order completion, in-order retire
    base = pay_seq;
    push(3); tick();
    cmp(0, 2); tick();
    cmp(0, 1); tick();
    chk("ooo_vct0", 32'(bus.dout_valid_ct), 0);
    cmp(0, 0); tick();
    chk("ooo_vct3", 32'(bus.dout_valid_ct), 3);
    for (int i = 0; i < 3; i++) chk("ooo_dout", 32'(bus.dout[i]), 32'(base + i));
    bus.dout_ready_ct = 3'd2; tick();
    chk("part_vct", 32'(bus.dout_valid_ct), 1);
    chk("part_count", 32'(bus.count), 1);
    bus.dout_ready_ct = 3'd3; tick();
    chk("part_empty", 32'(bus.count), 0);

    // wrap across slot 15 -> 0
    do_flush();
    for (int k = 0; k < 4; k++) round(3, 3 * k);
    round(2, 12);
    chk("wrap_tag0", 32'(bus.din_tags[0]), 14);
    chk("wrap_tag1", 32'(bus.din_tags[1]), 15);
    chk("wrap_tag2", 32'(bus.din_tags[2]), 0);
    base = pay_seq;
    push(3); tick();
    push(1); tick();
    cmp(0, 14); cmp(1, 15); cmp(2, 0); tick();
    cmp(0, 1); tick();
    chk("wrap_vct", 32'(bus.dout_valid_ct), 3);
    for (int i = 0; i < 3; i++) chk("wrap_dout", 32'(bus.dout[i]), 32'(base + i));
    bus.dout_ready_ct = 3'd3; tick();
    chk("wrap_vct1", 32'(bus.dout_valid_ct), 1);
    chk("wrap_dout1", 32'(bus.dout[0]), 32'(base + 3));
    bus.dout_ready_ct = 3'd3; tick();
    chk("wrap_empty", 32'(bus.count), 0);

    // illegal oversize requests saturate
    do_flush();
    push(3); bus.din_valid_ct = 3'd5; tick();
    chk("sat_push", 32'(bus.count), 3);
    cmp(0, 0); cmp(1, 1); cmp(2, 2); tick();
    bus.dout_ready_ct = 3'd7; tick();
    chk("sat_ret", 32'(bus.count), 0);

    // full buffer: retire does not free push room the same cycle
    do_flush();
    for (int k = 0; k < 6; k++) begin push(3); tick(); end
    cmp(0, 0); cmp(1, 1); cmp(2, 2); tick();
    chk("fr_vct", 32'(bus.dout_valid_ct), 3);
    bus.dout_ready_ct = 3'd3; push(3); tick();
    chk("fr_count", 32'(bus.count), 13);
    chk("fr_ready", 32'(bus.din_ready_ct), 3);

    // completions to empty slots are dropped
    do_flush();
    cmp(0, 7); tick();
    push(3); tick();
    push(3); tick();
    push(2); cmp(1, 7); tick();
    cmp(0, 0); cmp(1, 1); cmp(2, 2); tick();
    cmp(0, 3); cmp(1, 4); cmp(2, 5); tick();
    cmp(0, 6); tick();
    for (int k = 0; k < 3; k++) begin bus.dout_ready_ct = 3'd3; tick(); end
    chk("ghost_count", 32'(bus.count), 1);
    chk("ghost_vct", 32'(bus.dout_valid_ct), 0);

    // flush beats same-cycle push, completion and retire
    do_flush();
    push(3); tick();
    push(3); tick();
    push(2); tick();
    cmp(0, 0); cmp(1, 1); cmp(2, 2); tick();
    cmp(0, 3); tick();
    chk("pre_count", 32'(bus.count), 8);
    bus.flush = 1'b1; push(3); cmp(0, 4); bus.dout_ready_ct = 3'd2;
    chk("fl_cycle_vct", 32'(bus.dout_valid_ct), 3);
    tick();
    chk("fl_count", 32'(bus.count), 0);
    chk("fl_vct", 32'(bus.dout_valid_ct), 0);
    chk("fl_ready", 32'(bus.din_ready_ct), 3);
    chk("fl_tail", 32'(bus.din_tags[0]), 0);

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
